// File: rtl/cpu_pkg.sv
// Shared definitions for the register file and its datapath neighbours:
// default sizes, the architectural zero-register address and the FSM encoding.
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    // Architectural zero register (hardwired to 0 when ZERO_REG=1).
    localparam int REG_ZERO   = 0;

    localparam int STATE_W    = 1;

    // CLEAR sweeps zeros through the array; RUN is normal operation.
    typedef enum logic [STATE_W-1:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: one flop per register, set by a reserve and
// cleared by a write-back, with the set taking priority when both target the
// same register in the same cycle. Two combinational lookup ports.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              busy1,
    output logic              busy2
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Next busy vector: apply the clear first so a same-address reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    // Busy flops; reset drops every pending reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy1 = busy_q[raddr1];
    assign busy2 = busy_q[raddr2];

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with a reset-time clear sweep, optional write-to-read bypass,
// optional hardwired zero register and a busy scoreboard for stall control.
// dbg_state mirrors the sweep FSM state for observation.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ready,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [ADDR_W-1:0]  raddr1,
    input  logic [ADDR_W-1:0]  raddr2,
    output logic [DATA_W-1:0]  rdata1,
    output logic [DATA_W-1:0]  rdata2,
    output logic               busy1,
    output logic               busy2,
    input  logic               rsv_en,
    input  logic [ADDR_W-1:0]  rsv_addr,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              ready_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              we_eff;
    logic              rsv_eff;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic              sb_busy1;
    logic              sb_busy2;

    // A port address is zero-suppressed only when the zero register is enabled.
    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ZERO_ADDR);
    endfunction

    // Writes and reserves only count in RUN, outside reset, and never to r0.
    assign we_eff  = ready_q && !rst && we     && !is_zero(waddr);
    assign rsv_eff = ready_q && !rst && rsv_en && !is_zero(rsv_addr);

    // Sweep FSM: walk the index over every register, then hand over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_CLEAR;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Single array write port shared between the clear sweep and write-back.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = waddr;
        arr_wdata = wdata;
        if (!rst && state_q == ST_CLEAR) begin
            arr_we    = 1'b1;
            arr_waddr = idx_q;
            arr_wdata = '0;
        end else if (we_eff) begin
            arr_we    = 1'b1;
        end
    end

    // Register array; its only reset is the sweep above.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_waddr] <= arr_wdata;
        end
    end

    // Read ports: masked until ready, r0 forced to zero, optional bypass.
    always_comb begin
        rdata1   = mem_q[raddr1];
        rdata2   = mem_q[raddr2];
        dbg_data = mem_q[dbg_addr];
        if (BYPASS != 0 && we_eff && raddr1 == waddr) begin
            rdata1 = wdata;
        end
        if (BYPASS != 0 && we_eff && raddr2 == waddr) begin
            rdata2 = wdata;
        end
        if (!ready_q || is_zero(raddr1)) begin
            rdata1 = '0;
        end
        if (!ready_q || is_zero(raddr2)) begin
            rdata2 = '0;
        end
        if (!ready_q || is_zero(dbg_addr)) begin
            dbg_data = '0;
        end
    end

    rf_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (rsv_eff),
        .set_addr (rsv_addr),
        .clr_en   (we_eff),
        .clr_addr (waddr),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .busy1    (sb_busy1),
        .busy2    (sb_busy2)
    );

    assign busy1     = ready_q && sb_busy1;
    assign busy2     = ready_q && sb_busy2;
    assign ready     = ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a bypassing instance and a non-bypassing
// instance share every input; both are compared against a register-level
// reference model (edge count to ready, plain arrays for data and busy bits).
module tb_regfile_scoreboard;
    import cpu_pkg::*;

    localparam int DW = 32;
    localparam int DP = 32;
    localparam int AW = 5;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared inputs ----------------
    logic          rst      = 1'b1;
    logic          we       = 1'b0;
    logic [AW-1:0] waddr    = '0;
    logic [DW-1:0] wdata    = '0;
    logic [AW-1:0] raddr1   = '0;
    logic [AW-1:0] raddr2   = '0;
    logic          rsv_en   = 1'b0;
    logic [AW-1:0] rsv_addr = '0;
    logic [AW-1:0] dbg_addr = '0;

    // ---------------- outputs ----------------
    logic          ready_b, busy1_b, busy2_b;
    logic [DW-1:0] rdata1_b, rdata2_b, dbg_data_b;
    logic [STATE_W-1:0] state_b;
    logic          ready_n, busy1_n, busy2_n;
    logic [DW-1:0] rdata1_n, rdata2_n, dbg_data_n;
    logic [STATE_W-1:0] state_n;

    regfile_scoreboard #(.DATA_W(DW), .DEPTH(DP), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .ready(ready_b), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b), .rdata2(rdata2_b),
        .busy1(busy1_b), .busy2(busy2_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_b), .dbg_state(state_b)
    );

    regfile_scoreboard #(.DATA_W(DW), .DEPTH(DP), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .ready(ready_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n), .rdata2(rdata2_n),
        .busy1(busy1_n), .busy2(busy2_n), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data_n), .dbg_state(state_n)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DP];
    bit            m_busy[DP];
    bit            m_ready = 1'b0;
    int            m_edges = 0;

    int checks   = 0;
    int failures = 0;

    // Apply one clock edge's worth of architectural effect.
    task automatic model_edge();
        if (rst) begin
            m_edges = 0;
            m_ready = 1'b0;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else if (!m_ready) begin
            m_edges++;
            if (m_edges == DP) begin
                m_ready = 1'b1;
                foreach (m_mem[i]) m_mem[i] = '0;
            end
        end else begin
            if (we && waddr != 0) begin
                m_mem[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) begin
                m_busy[rsv_addr] = 1'b1;
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
        if (!m_ready || a == 0) return '0;
        if (byp && we && waddr == a) return wdata;
        return m_mem[a];
    endfunction

    function automatic logic [DW-1:0] exp_busy(input logic [AW-1:0] a);
        if (!m_ready) return '0;
        return {31'd0, m_busy[a]};
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic r, input logic [AW-1:0] ra,
                         input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                         input logic [AW-1:0] da);
        we = w; waddr = wa; wdata = wd; rsv_en = r; rsv_addr = ra;
        raddr1 = a1; raddr2 = a2; dbg_addr = da;
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, ".ready"},  {31'd0, ready_b},  {31'd0, m_ready});
        chk({tag, ".state"},  {31'd0, state_b},  {31'd0, (m_ready ? ST_RUN : ST_CLEAR)});
        chk({tag, ".rdata1"}, rdata1_b,  exp_read(raddr1, 1));
        chk({tag, ".rdata2"}, rdata2_b,  exp_read(raddr2, 1));
        chk({tag, ".dbg"},    dbg_data_b, exp_read(dbg_addr, 0));
        chk({tag, ".busy1"},  {31'd0, busy1_b}, exp_busy(raddr1));
        chk({tag, ".busy2"},  {31'd0, busy2_b}, exp_busy(raddr2));
        chk({tag, ".nb_rdata1"}, rdata1_n, exp_read(raddr1, 0));
        chk({tag, ".nb_rdata2"}, rdata2_n, exp_read(raddr2, 0));
        chk({tag, ".nb_busy1"},  {31'd0, busy1_n}, exp_busy(raddr1));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;

        // Reset held three edges.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        check_all("reset");

        // Release; write attempts during the sweep must be ignored.
        rst = 1'b0;
        drive(1, 2, 32'hFF, 1, 6, 2, 6, 2);
        for (int i = 1; i <= DP; i++) begin
            step();
            chk("ready_at_edge", {31'd0, ready_b}, {31'd0, (i == DP)});
            if (i == DP) drive(0, 0, 0, 0, 0, 2, 6, 2);
            check_all("sweep");
        end

        // Every register cleared, no busy bits.
        for (int i = 0; i < DP; i++) begin
            drive(0, 0, 0, 0, 0, AW'(i), AW'(i), AW'(i));
            check_all("cleared");
            chk("cleared.dbg_zero", dbg_data_b, 32'h0);
        end

        // Bypass vs. no bypass on a same-cycle write/read.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 5);
        check_all("bypass_cycle");
        chk("bypass_cycle.b", rdata1_b, 32'hDEADBEEF);
        chk("bypass_cycle.nb", rdata1_n, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 5, 5, 5);
        check_all("bypass_after");
        chk("bypass_after.nb", rdata1_n, 32'hDEADBEEF);

        // Zero register ignores writes and reserves.
        drive(1, 0, 32'h12345678, 1, 0, 0, 0, 0);
        check_all("zero_cycle");
        chk("zero_cycle.rdata1", rdata1_b, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("zero_after");
        chk("zero_after.busy1", {31'd0, busy1_b}, 32'h0);

        // Scoreboard reserve, clear-on-write, and reserve-wins collision.
        drive(0, 0, 0, 1, 7, 7, 7, 7);
        check_all("rsv7_cycle");
        chk("rsv7_cycle.busy_not_bypassed", {31'd0, busy1_b}, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 7, 7, 7);
        check_all("rsv7_after");
        chk("rsv7_after.busy1", {31'd0, busy1_b}, 32'h1);
        drive(1, 7, 32'hA5, 0, 0, 7, 7, 7);
        step();
        drive(0, 0, 0, 0, 0, 7, 9, 7);
        check_all("wr7_after");
        chk("wr7_after.busy1", {31'd0, busy1_b}, 32'h0);
        chk("wr7_after.rdata1", rdata1_b, 32'hA5);
        drive(1, 9, 32'h99, 1, 9, 7, 9, 9);
        step();
        drive(0, 0, 0, 0, 0, 7, 9, 9);
        check_all("coll9_after");
        chk("coll9_after.busy2", {31'd0, busy2_b}, 32'h1);
        chk("coll9_after.rdata2", rdata2_b, 32'h99);

        // Randomised traffic against the model.
        for (int c = 0; c < 300; c++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, DP - 1));
            drive(1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DP - 1)),
                  ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DP - 1)),
                  AW'($urandom_range(0, DP - 1)), AW'($urandom_range(0, DP - 1)));
            check_all("rand");
            step();
        end

        // Reset mid-operation and again mid-sweep.
        drive(1, 3, 32'h55, 1, 4, 3, 4, 3);
        step();
        drive(0, 0, 0, 0, 0, 3, 4, 3);
        check_all("pre_rst");
        chk("pre_rst.reg3", rdata1_b, 32'h55);
        chk("pre_rst.busy4", {31'd0, busy2_b}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        check_all("mid_sweep");
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (!ready_b && n < 40) begin
            step();
            n++;
        end
        chk("mid_rst_ready_edges", n, DP);
        check_all("post_rst");
        chk("post_rst.reg3", rdata1_b, 32'h0);
        chk("post_rst.busy4", {31'd0, busy2_b}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
